// File: rtl/comp_1bit_bist.sv
// comp_1bit_bist: self-test sequencer for a 1-bit l/e/g comparator.
// It steps {a,b} through 00,01,10,11. Each vector is held for SETTLE_CYCLES
// before l/e/g are sampled and compared against the expected result.
// It then reports an error count and a pass flag.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           begin a sweep (honoured only while idle or done)
//   l, e, g         comparator outputs under test
//   a, b            registered stimulus to the comparator
//   busy            sweep in progress
//   done, pass      sweep finished; pass=1 iff err_count==0
//   err_count       number of failing vectors (0..4)
//   fail_valid, fail_vec, fail_lge
//                   first-failure capture, present only when
//                   COMP_BIST_CAPTURE_EN is defined
module comp_1bit_bist #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       l,
  input  logic       e,
  input  logic       g,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count
`ifdef COMP_BIST_CAPTURE_EN
  ,
  output logic       fail_valid,
  output logic [1:0] fail_vec,
  output logic [2:0] fail_lge
`endif
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned ERR_W = 3;
  localparam int unsigned VEC_W = 2;
  localparam int unsigned LGE_W = 3;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_e;

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VEC_W-1:0]   ab_q, ab_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               chk_vld_q, chk_vld_d;
  logic [VEC_W-1:0]   chk_vec_q, chk_vec_d;
  logic [LGE_W-1:0]   chk_lge_q, chk_lge_d;
  logic               accept;
  logic               mism;
`ifdef COMP_BIST_CAPTURE_EN
  logic               fv_q, fv_d;
  logic [VEC_W-1:0]   fvec_q, fvec_d;
  logic [LGE_W-1:0]   flge_q, flge_d;
`endif

  // Expected {l,e,g} for stimulus {a,b}
  function automatic logic [LGE_W-1:0] exp_lge(input logic [VEC_W-1:0] v);
    exp_lge = {~v[1] & v[0], ~(v[1] ^ v[0]), v[1] & ~v[0]};
  endfunction

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    ab_d      = idx_q;  // stimulus trails the index by one cycle
    chk_vld_d = 1'b0;
    chk_vec_d = chk_vec_q;
    chk_lge_d = chk_lge_q;
    accept    = start && ((state_q == IDLE) || (state_q == DONE));

    // Compare runs one cycle after the sample so err_count trails CHECK by an edge
    mism  = chk_vld_q && (chk_lge_q != exp_lge(chk_vec_q));
    err_d = err_q + ERR_W'(mism);
`ifdef COMP_BIST_CAPTURE_EN
    fv_d   = fv_q;
    fvec_d = fvec_q;
    flge_d = flge_q;
    if (mism && !fv_q) begin
      fv_d   = 1'b1;
      fvec_d = chk_vec_q;
      flge_d = chk_lge_q;
    end
`endif

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SETTLE;
          idx_d   = '0;
          cnt_d   = CNT_W'(SETTLE_CYCLES);
        end
      end
      SETTLE: begin
        // <=1 also keeps an illegal zero setting from wrapping the counter
        if (cnt_q <= CNT_W'(1)) state_d = CHECK;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      CHECK: begin
        chk_vld_d = 1'b1;
        chk_vec_d = idx_q;
        chk_lge_d = {l, e, g};
        if (idx_q != VEC_W'(3)) begin
          idx_d   = idx_q + VEC_W'(1);
          cnt_d   = CNT_W'(SETTLE_CYCLES);
          state_d = SETTLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      err_d     = '0;
      chk_vld_d = 1'b0;
`ifdef COMP_BIST_CAPTURE_EN
      fv_d   = 1'b0;
      fvec_d = '0;
      flge_d = '0;
`endif
    end

    busy_d = (state_q == SETTLE) || (state_q == CHECK);
    done_d = (state_q == DONE) && !accept;
    pass_d = done_d && (err_d == '0);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      ab_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      chk_vld_q <= 1'b0;
      chk_vec_q <= '0;
      chk_lge_q <= '0;
`ifdef COMP_BIST_CAPTURE_EN
      fv_q      <= 1'b0;
      fvec_q    <= '0;
      flge_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      ab_q      <= ab_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      chk_vld_q <= chk_vld_d;
      chk_vec_q <= chk_vec_d;
      chk_lge_q <= chk_lge_d;
`ifdef COMP_BIST_CAPTURE_EN
      fv_q      <= fv_d;
      fvec_q    <= fvec_d;
      flge_q    <= flge_d;
`endif
    end
  end

  assign a         = ab_q[1];
  assign b         = ab_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
`ifdef COMP_BIST_CAPTURE_EN
  assign fail_valid = fv_q;
  assign fail_vec   = fvec_q;
  assign fail_lge   = flge_q;
`endif

endmodule

// File: tb/tb_comp_1bit_bist.sv
module tb_comp_1bit_bist;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] a_o, b_o, busy_o, done_o, pass_o;
  logic [1:0] l_i, e_i, g_i;
  logic [2:0] err_o [2];
  logic [2:0] lge0, lge1;
`ifdef COMP_BIST_CAPTURE_EN
  logic [1:0] fv_o;
  logic [1:0] fvec_o [2];
  logic [2:0] flge_o [2];
`endif

  logic [2:0] mask [4];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t_s = 0;
  int t_last = 0;
  bit chk_en = 1'b0;

  // Reference model state, per instance (0: S=2, 1: S=1)
  bit         started [2];
  int         t0 [2];
  logic [1:0] ab_hold [2];
  logic [2:0] mk [2][4];

  always #5 clk = ~clk;

  function automatic int sval(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic logic [2:0] golden(input int v);
    int av = v / 2;
    int bv = v % 2;
    return {av < bv, av == bv, av > bv};
  endfunction

  // Comparators under test: golden response with a per-vector fault mask
  assign lge0 = golden(int'({a_o[0], b_o[0]})) ^ mask[{a_o[0], b_o[0]}];
  assign lge1 = golden(int'({a_o[1], b_o[1]})) ^ mask[{a_o[1], b_o[1]}];
  assign {l_i[0], e_i[0], g_i[0]} = lge0;
  assign {l_i[1], e_i[1], g_i[1]} = lge1;

  comp_1bit_bist #(.SETTLE_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst), .start(start),
    .l(l_i[0]), .e(e_i[0]), .g(g_i[0]),
    .a(a_o[0]), .b(b_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .pass(pass_o[0]), .err_count(err_o[0])
`ifdef COMP_BIST_CAPTURE_EN
    , .fail_valid(fv_o[0]), .fail_vec(fvec_o[0]), .fail_lge(flge_o[0])
`endif
  );

  comp_1bit_bist #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start),
    .l(l_i[1]), .e(e_i[1]), .g(g_i[1]),
    .a(a_o[1]), .b(b_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .pass(pass_o[1]), .err_count(err_o[1])
`ifdef COMP_BIST_CAPTURE_EN
    , .fail_valid(fv_o[1]), .fail_vec(fvec_o[1]), .fail_lge(flge_o[1])
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Model update: track accepted starts and resets as seen at each edge
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        started[i] = 1'b0;
        ab_hold[i] = 2'b00;
      end else if (start && (!started[i] || (cyc - t0[i] >= 4 * (sval(i) + 1) + 1))) begin
        ab_hold[i] = started[i] ? 2'b11 : 2'b00;
        started[i] = 1'b1;
        t0[i]      = cyc;
        for (int k = 0; k < 4; k++) mk[i][k] = mask[k];
      end
    end
  end

  // Every-cycle compare against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int s, n, kk, eerr;
        logic [1:0] eab;
        bit ebusy, edone, efv;
`ifdef COMP_BIST_CAPTURE_EN
        int efk;
        efk = 0;
`endif
        s = sval(i);
        n = cyc - t0[i];
        eerr = 0;
        efv = 1'b0;
        if (!started[i])  eab = 2'b00;
        else if (n < 1)   eab = ab_hold[i];
        else begin
          kk = (n - 1) / (s + 1);
          if (kk > 3) kk = 3;
          eab = 2'(kk);
        end
        ebusy = started[i] && (n >= 1) && (n <= 4 * (s + 1));
        edone = started[i] && (n >= 4 * (s + 1) + 1);
        if (started[i]) begin
          for (int k = 0; k < 4; k++) begin
            if ((mk[i][k] != 3'b000) && ((k + 1) * (s + 1) + 1 <= n)) begin
              eerr++;
              if (!efv) begin
                efv = 1'b1;
`ifdef COMP_BIST_CAPTURE_EN
                efk = k;
`endif
              end
            end
          end
        end
        chk($sformatf("ab[%0d]", i), 32'({a_o[i], b_o[i]}), 32'(eab));
        chk($sformatf("busy[%0d]", i), 32'(busy_o[i]), 32'(ebusy));
        chk($sformatf("done[%0d]", i), 32'(done_o[i]), 32'(edone));
        chk($sformatf("pass[%0d]", i), 32'(pass_o[i]), 32'(edone && (eerr == 0)));
        chk($sformatf("err_count[%0d]", i), 32'(err_o[i]), 32'(eerr));
`ifdef COMP_BIST_CAPTURE_EN
        chk($sformatf("fail_valid[%0d]", i), 32'(fv_o[i]), 32'(efv));
        chk($sformatf("fail_vec[%0d]", i), 32'(fvec_o[i]), efv ? 32'(efk) : 32'd0);
        chk($sformatf("fail_lge[%0d]", i), 32'(flge_o[i]),
            efv ? 32'(golden(efk) ^ mk[i][efk]) : 32'd0);
`endif
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    t_s    = cyc;
    t_last = cyc;
  endtask

  task automatic wait_edge(input int n);
    while (cyc < t_s + n) @(negedge clk);
  endtask

  task automatic wait_quiet();
    int budget = 0;
    while (!((cyc >= t_last + 2) && (busy_o == 2'b00))) begin
      @(negedge clk);
      budget++;
      if (budget > 100) begin
        chk("wait_quiet_timeout", 32'd1, 32'd0);
        break;
      end
    end
  endtask

  task automatic set_mask(input logic [2:0] m0, input logic [2:0] m1,
                          input logic [2:0] m2, input logic [2:0] m3);
    mask[0] = m0; mask[1] = m1; mask[2] = m2; mask[3] = m3;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    set_mask(3'b000, 3'b000, 3'b000, 3'b000);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_ab", 32'({a_o[0], b_o[0]}), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Golden comparator, both settle settings
    pulse_start();
    wait_edge(1);  chk("g_ab_e1", 32'({a_o[0], b_o[0]}), 32'd0);
    wait_edge(3);  chk("g1_ab_e3", 32'({a_o[1], b_o[1]}), 32'd1);
    wait_edge(4);  chk("g_ab_e4", 32'({a_o[0], b_o[0]}), 32'd1);
    wait_edge(7);  chk("g_ab_e7", 32'({a_o[0], b_o[0]}), 32'd2);
                   chk("g1_ab_e7", 32'({a_o[1], b_o[1]}), 32'd3);
    wait_edge(8);  chk("g1_done_e8", 32'(done_o[1]), 32'd0);
    wait_edge(9);  chk("g1_done_e9", 32'(done_o[1]), 32'd1);
                   chk("g1_pass_e9", 32'(pass_o[1]), 32'd1);
    wait_edge(10); chk("g_ab_e10", 32'({a_o[0], b_o[0]}), 32'd3);
    wait_edge(12); chk("g_done_e12", 32'(done_o[0]), 32'd0);
    wait_edge(13); chk("g_done_e13", 32'(done_o[0]), 32'd1);
                   chk("g_pass_e13", 32'(pass_o[0]), 32'd1);
                   chk("g_busy_e13", 32'(busy_o[0]), 32'd0);

    // e stuck at 0: vectors 00 and 11 fail
    set_mask(3'b010, 3'b000, 3'b000, 3'b010);
    pulse_start();
    wait_edge(13);
    chk("estuck_err", 32'(err_o[0]), 32'd2);
    chk("estuck_pass", 32'(pass_o[0]), 32'd0);
    chk("estuck_err1", 32'(err_o[1]), 32'd2);
`ifdef COMP_BIST_CAPTURE_EN
    chk("estuck_fv", 32'(fv_o[0]), 32'd1);
    chk("estuck_fvec", 32'(fvec_o[0]), 32'd0);
    chk("estuck_flge", 32'(flge_o[0]), 32'd0);
`endif

    // l and g swapped: vectors 01 and 10 fail
    set_mask(3'b000, 3'b101, 3'b101, 3'b000);
    pulse_start();
    wait_edge(13);
    chk("swap_err", 32'(err_o[0]), 32'd2);
    chk("swap_pass", 32'(pass_o[0]), 32'd0);
`ifdef COMP_BIST_CAPTURE_EN
    chk("swap_fvec", 32'(fvec_o[0]), 32'd1);
    chk("swap_flge", 32'(flge_o[0]), 32'd1);
`endif

    // Reset mid-sweep at edge 5, then a clean sweep
    set_mask(3'b000, 3'b000, 3'b000, 3'b000);
    pulse_start();
    wait_edge(4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    t_last = cyc;
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_ab", 32'({a_o[0], b_o[0]}), 32'd0);
    chk("mid_rst_err", 32'(err_o[0]), 32'd0);
    pulse_start();
    wait_edge(13);
    chk("post_rst_pass", 32'(pass_o[0]), 32'd1);

    // start while busy is ignored; start in DONE restarts
    set_mask(3'b010, 3'b000, 3'b000, 3'b010);
    pulse_start();
    wait_edge(5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t_last = cyc;
    wait_edge(12); chk("ign_done_e12", 32'(done_o[0]), 32'd0);
    wait_edge(13); chk("ign_done_e13", 32'(done_o[0]), 32'd1);
                   chk("ign_err_e13", 32'(err_o[0]), 32'd2);
    pulse_start();
    chk("restart_done", 32'(done_o[0]), 32'd0);
    chk("restart_err", 32'(err_o[0]), 32'd0);
    wait_edge(13);
    chk("restart_err_final", 32'(err_o[0]), 32'd2);

    // Randomized sweeps with random faults, aborts and stray starts
    for (int it = 0; it < 40; it++) begin
      for (int v = 0; v < 4; v++)
        mask[v] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      pulse_start();
      begin
        int r = int'($urandom_range(0, 9));
        if (r < 2) begin
          wait_edge(int'($urandom_range(1, 12)));
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          t_last = cyc;
        end else if (r < 5) begin
          wait_edge(int'($urandom_range(1, 12)));
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
          t_last = cyc;
        end
      end
      wait_quiet();
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/comp_1bit_bist.md
# comp_1bit_bist

Synthesizable on-chip stimulus generator and response checker for the 1-bit comparator. It drives the comparator inputs `a` and `b` through all four input vectors and samples the returned `l`/`e`/`g` outputs. Each sample is checked against the expected compare result, and the block reports an error count and a pass/fail flag. It sits next to `comp_1bit_nand` (or any `l,e,g` comparator) on the FPGA so the comparator can be self-tested without a simulator.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling. Legal range 1..255; 0 is illegal.

Ports:
- `clk` input 1: single clock, rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin a sweep; sampled in IDLE or DONE only.
- `l`, `e`, `g` input 1 each: comparator outputs under test.
- `a`, `b` output 1 each: registered comparator stimulus.
- `busy` output 1: sweep in progress.
- `done` output 1: sweep finished; held until next accepted `start` or `rst`.
- `pass` output 1: valid while `done`; 1 iff `err_count` = 0.
- `err_count` output 3: number of failing vectors, 0..4.
- `fail_valid` output 1, only with `COMP_BIST_CAPTURE_EN`: a failure was captured.
- `fail_vec` output 2, only with `COMP_BIST_CAPTURE_EN`: first failing `{a,b}`.
- `fail_lge` output 3, only with `COMP_BIST_CAPTURE_EN`: observed `{l,e,g}` at the first failure.

## Operation
- Vector order: `{a,b}` = 00, 01, 10, 11, held in a 2-bit index.
- Expected response: `l` = (a<b), `e` = (a==b), `g` = (a>b). As `{l,e,g}`: 00→010, 01→100, 10→001, 11→010.
- A vector fails if any of `l`, `e`, `g` mismatches. Each vector adds at most 1 to `err_count`.
- FSM states:
  - IDLE: `busy`=0, `done`=0. `start`=1 → SETTLE. Clears `err_count`, loads vector 00, loads wait counter.
  - SETTLE: hold `a`/`b` for `SETTLE_CYCLES` cycles, then → CHECK.
  - CHECK: one cycle. Sample `l,e,g` and compare. If index < 3, increment index and → SETTLE. Otherwise → DONE.
  - DONE: `done`=1, `busy`=0, `pass` registered. `start`=1 → SETTLE exactly as from IDLE. `done`/`pass` drop on that same edge.
- `start` in SETTLE or CHECK is ignored.
- `a`, `b` hold their last value (11) in DONE. They return to 00 only on reset or a new start.

## Timing
- Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_valid`=0, `fail_vec`=00, `fail_lge`=000. State is IDLE.
- Reset wins over `start` on the same edge. Reset mid-sweep aborts on that edge with no partial results kept.
- Cycle numbering: `start` is sampled high at edge 0.
  - Vector k appears on `a`/`b` after edge 1+k(S+1), where S = `SETTLE_CYCLES`.
  - `l,e,g` are sampled at edge (k+1)(S+1).
  - `done`=1 after edge 4(S+1)+1. For S=2 this is edge 13; for S=1, edge 9.
- `busy` is 1 from edge 1 through the final CHECK cycle. It falls on the same edge that `done` rises.
- `err_count` updates on the edge after each CHECK sample. It is final by the time `done` rises.
- Wait counter is 8 bits and must not wrap for legal `SETTLE_CYCLES`.

## Configuration
- `COMP_BIST_CAPTURE_EN` defined:
  - Adds `fail_valid`, `fail_vec`, `fail_lge`.
  - The first failing vector in a sweep latches `fail_vec`/`fail_lge` and sets `fail_valid`. Later failures do not overwrite them.
  - All three clear on an accepted `start` or on `rst`.
- `COMP_BIST_CAPTURE_EN` undefined: these ports and registers are absent. All other behaviour is identical.

## Test plan
- Golden comparator, S=2, `start` pulse at edge 0 → `a,b` step 00/01/10/11 at edges 1/4/7/10. `done`=1 at edge 13 with `pass`=1, `err_count`=0, `busy`=0.
- Comparator with `e` stuck at 0 → `err_count`=2 (vectors 00 and 11), `pass`=0. With capture: `fail_vec`=00, `fail_lge`=000, `fail_valid`=1.
- Comparator with `l` and `g` swapped → `err_count`=2 (vectors 01 and 10). With capture: `fail_vec`=01, `fail_lge`=001.
- `rst` asserted at edge 5 mid-sweep → all outputs at reset values after edge 5. A new `start` then completes a full sweep with `pass`=1.
- `start` re-pulsed at edge 6 (busy) → ignored, `done` still at edge 13. Then `start` in DONE → `done`/`pass`/`err_count` clear on that edge and the sweep repeats.
- S=1 golden run → vectors at edges 1/3/5/7, `done`=1 at edge 9, `pass`=1.
